// File: rtl/apb_req_master.sv
// APB master that turns a valid/ready request into one APB transfer
// and returns a registered valid/ready response, with an optional PREADY timeout.
module apb_req_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         wait_cnt, wait_cnt_d;
  logic                  timeout_hit;
  logic                  psel_d, penable_d, pwrite_d;
  logic                  rsp_valid_d, rsp_err_d, req_ready_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;

  always_comb begin
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST);

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = SETUP;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_write ? req_wdata : '0;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = RESP;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase

    // Handshake/strobe outputs are registered from the next state
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      req_ready <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: directed vector table, hand-written
// reset/back-to-back sequences, and random transactions against a reference model.
module tb_apb_req_master;

  localparam int TO = 16;

  logic        PCLK, PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_req_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] prdata;
    logic        slverr;
    int unsigned rdelay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_cyc;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
    chk("penable_without_psel", 64'(PENABLE & ~PSEL), 64'd0);
  endtask

  // Expected result from the transfer rules: abort when PREADY stays low for TO cycles
  function automatic txn_t model(input txn_t t);
    txn_t r;
    logic abort;
    r = t;
    abort       = (TO != 0) && (t.waits >= TO);
    r.exp_cyc   = abort ? TO : t.waits + 1;
    r.exp_rdata = (abort || t.write) ? 32'd0 : t.prdata;
    r.exp_err   = abort ? 1'b1 : t.slverr;
    return r;
  endfunction

  // Entered and left at a falling edge with the block idle
  task automatic run_txn(input txn_t t);
    int unsigned acc;
    logic done;
    logic [31:0] exp_pwdata;
    exp_pwdata = t.write ? t.wdata : 32'd0;
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = t.write; req_addr = t.addr; req_wdata = t.wdata;
    PRDATA = t.prdata; PSLVERR = t.slverr; PREADY = 1'b0; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0; req_write = ~t.write; req_addr = ~t.addr; req_wdata = ~t.wdata;
    chk("setup_psel", 64'(PSEL), 64'd1);
    chk("setup_penable", 64'(PENABLE), 64'd0);
    chk("setup_paddr", 64'(PADDR), 64'(t.addr));
    chk("setup_pwrite", 64'(PWRITE), 64'(t.write));
    chk("setup_pwdata", 64'(PWDATA), 64'(exp_pwdata));
    chk("setup_req_ready", 64'(req_ready), 64'd0);
    acc = 0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (PSEL && PENABLE) begin
        acc++;
        chk("access_paddr", 64'(PADDR), 64'(t.addr));
        chk("access_pwdata", 64'(PWDATA), 64'(exp_pwdata));
        chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
        PREADY = (acc == t.waits + 1);
      end else begin
        done = 1'b1;
        break;
      end
    end
    PREADY = 1'b0;
    chk("access_bound_reached", 64'(done), 64'd1);
    chk("access_cycles", 64'(acc), 64'(t.exp_cyc));
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_rdata", 64'(rsp_rdata), 64'(t.exp_rdata));
    chk("resp_err", 64'(rsp_err), 64'(t.exp_err));
    chk("resp_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < int'(t.rdelay); i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      step();
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(t.exp_rdata));
      chk("hold_rsp_err", 64'(rsp_err), 64'(t.exp_err));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_psel", 64'(PSEL), 64'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_psel", 64'(PSEL), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tbl[7];
    txn_t t;
    int acc_cyc[$];
    logic [7:0] last_addr;
    logic accepted;

    //             wr    addr   wdata         waits prdata        err   rd  exp_rdata     exp_err cyc
    tbl[0] = '{1'b0, 8'h3C, 32'h0,        0,  32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0,  1};
    tbl[1] = '{1'b1, 8'h10, 32'h12345678, 3,  32'hFFFFFFFF, 1'b1, 0, 32'h0,        1'b1,  4};
    tbl[2] = '{1'b0, 8'h21, 32'h0,        16, 32'hAAAA5555, 1'b0, 1, 32'h0,        1'b1, 16};
    tbl[3] = '{1'b0, 8'h22, 32'h0,        15, 32'h0BADF00D, 1'b0, 0, 32'h0BADF00D, 1'b0, 16};
    tbl[4] = '{1'b0, 8'h7F, 32'h0,        0,  32'h5A5A5A5A, 1'b1, 5, 32'h5A5A5A5A, 1'b1,  1};
    tbl[5] = '{1'b1, 8'hC3, 32'hCAFEF00D, 15, 32'h11111111, 1'b0, 2, 32'h0,        1'b0, 16};
    tbl[6] = '{1'b1, 8'hFF, 32'h87654321, 40, 32'h22222222, 1'b0, 0, 32'h0,        1'b1, 16};

    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    step();
    req_valid = 1'b1;
    step();
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    PRESETn = 1'b1;
    step();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset in the middle of an ACCESS phase
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h55; PREADY = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("pre_rst_access", 64'(PSEL & PENABLE), 64'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 64'(PSEL), 64'd0);
    chk("async_rst_penable", 64'(PENABLE), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_paddr", 64'(PADDR), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    PRESETn = 1'b1;
    step();
    chk("rerst_req_ready", 64'(req_ready), 64'd1);
    chk("rerst_no_rsp", 64'(rsp_valid), 64'd0);
    t = '{1'b0, 8'h56, 32'h0, 1, 32'h13572468, 1'b0, 0, 32'h0, 1'b0, 0};
    run_txn(model(t));

    // Back-to-back requests, zero-wait slave, response always accepted
    req_valid = 1'b1; PREADY = 1'b1; rsp_ready = 1'b1; PSLVERR = 1'b0; req_write = 1'b1;
    accepted = 1'b0;
    last_addr = '0;
    for (int c = 0; c < 16; c++) begin
      if (accepted) chk("b2b_paddr", 64'(PADDR), 64'(last_addr));
      accepted = req_ready;
      if (req_ready) begin
        acc_cyc.push_back(c);
        last_addr = 8'(c * 7 + 3);
      end
      req_addr = 8'(c * 7 + 3);
      step();
    end
    req_valid = 1'b0; PREADY = 1'b0; rsp_ready = 1'b0;
    chk("b2b_accept_count", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
    chk("b2b_end_idle", 64'(req_ready), 64'd1);

    for (int n = 0; n < 40; n++) begin
      t.write  = 1'($urandom);
      t.addr   = 8'($urandom);
      t.wdata  = $urandom;
      t.waits  = $urandom_range(0, 20);
      t.prdata = $urandom;
      t.slverr = 1'($urandom);
      t.rdelay = $urandom_range(0, 3);
      run_txn(model(t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
